// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the instruction sequencer: RV32I opcode fields, ALU control
// values, immediate-select codes and the sequencer state type.
package alu_ctrl_pkg;

   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [2:0] F3_ADD     = 3'b000;
   localparam logic [2:0] F3_BNE     = 3'b001;
   localparam logic [6:0] F7_ADD     = 7'b0000000;

   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_SUB = 1'b1;

   localparam logic IMM_SEL_I = 1'b0;
   localparam logic IMM_SEL_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      EXEC   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/instr_sequencer_imm_ext.sv
// imm_ext: combinational sign extension of the RV32I I-type or B-type immediate,
// chosen by imm_sel, to DATA_WIDTH bits.
module imm_ext
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [31:0]           word,
   input  logic                  imm_sel,
   output logic [DATA_WIDTH-1:0] imm
);

   // Immediate field extraction and sign extension
   always_comb begin
      imm = '0;
      case (imm_sel)
         IMM_SEL_I: imm = {{(DATA_WIDTH-12){word[31]}}, word[31:20]};
         IMM_SEL_B: imm = {{(DATA_WIDTH-13){word[31]}}, word[31], word[7],
                           word[30:25], word[11:8], 1'b0};
         default:   imm = '0;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: three-state (IDLE/DECODE/EXEC) control sequencer for ADDI, ADD and BNE.
// Optional macro INSTR_SEQ_RETIRE_CNT_EN adds a retired-instruction counter output.
module instr_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int                    DATA_WIDTH          = 32,
   parameter int                    REG_FILE_ADDR_WIDTH = 5,
   parameter logic [DATA_WIDTH-1:0] RESET_PC            = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           instr_valid,
   input  logic [31:0]                    instr,
   output logic                           instr_ready,
   input  logic                           EQ,
   output logic [REG_FILE_ADDR_WIDTH-1:0] AD1,
   output logic [REG_FILE_ADDR_WIDTH-1:0] AD2,
   output logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
   output logic                           WE3,
   output logic                           ALUsrc,
   output logic                           ALUctrl,
   output logic [DATA_WIDTH-1:0]          ImmOp,
   output logic [DATA_WIDTH-1:0]          pc,
   output logic                           retire,
   output logic                           illegal
`ifdef INSTR_SEQ_RETIRE_CNT_EN
   ,
   output logic [DATA_WIDTH-1:0]          retire_cnt
`endif
);

   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

   seq_state_t            state;
   logic [31:0]           ir;
   logic                  legal;
   logic                  is_bne;
   logic                  dec_legal;
   logic                  dec_bne;
   logic                  dec_alusrc;
   logic                  dec_aluctrl;
   logic                  dec_use_imm;
   logic [31:0]           imm_word;
   logic                  imm_sel;
   logic [DATA_WIDTH-1:0] imm_val;

   assign instr_ready = (state == IDLE);

   // Decode the offered word so the control registers are valid throughout DECODE
   always_comb begin
      dec_legal   = 1'b0;
      dec_bne     = 1'b0;
      dec_alusrc  = 1'b0;
      dec_aluctrl = ALU_ADD;
      dec_use_imm = 1'b0;
      if (instr[6:0] == OPC_OPIMM && instr[14:12] == F3_ADD) begin
         dec_legal   = 1'b1;
         dec_alusrc  = 1'b1;
         dec_use_imm = 1'b1;
      end else if (instr[6:0] == OPC_OP && instr[14:12] == F3_ADD && instr[31:25] == F7_ADD) begin
         dec_legal = 1'b1;
      end else if (instr[6:0] == OPC_BRANCH && instr[14:12] == F3_BNE) begin
         dec_legal   = 1'b1;
         dec_bne     = 1'b1;
         dec_aluctrl = ALU_SUB;
      end else begin
         dec_legal = 1'b0;
      end
   end

   // One extender serves both the I-type immediate at accept and the branch offset in EXEC
   always_comb begin
      imm_word = ir;
      imm_sel  = IMM_SEL_B;
      if (state == IDLE) begin
         imm_word = instr;
         imm_sel  = IMM_SEL_I;
      end else begin
         imm_word = ir;
         imm_sel  = IMM_SEL_B;
      end
   end

   imm_ext #(.DATA_WIDTH(DATA_WIDTH)) u_imm_ext (
      .word    (imm_word),
      .imm_sel (imm_sel),
      .imm     (imm_val)
   );

   // Sequencer state, PC and registered datapath controls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ir      <= 32'h0000_0000;
         pc      <= RESET_PC;
         legal   <= 1'b0;
         is_bne  <= 1'b0;
         AD1     <= '0;
         AD2     <= '0;
         AD3     <= '0;
         WE3     <= 1'b0;
         ALUsrc  <= 1'b0;
         ALUctrl <= 1'b0;
         ImmOp   <= '0;
         retire  <= 1'b0;
         illegal <= 1'b0;
      end else begin
         WE3     <= 1'b0;
         retire  <= 1'b0;
         illegal <= 1'b0;
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  state   <= DECODE;
                  ir      <= instr;
                  legal   <= dec_legal;
                  is_bne  <= dec_bne;
                  AD1     <= REG_FILE_ADDR_WIDTH'(instr[19:15]);
                  AD2     <= REG_FILE_ADDR_WIDTH'(instr[24:20]);
                  AD3     <= REG_FILE_ADDR_WIDTH'(instr[11:7]);
                  ALUsrc  <= dec_alusrc;
                  ALUctrl <= dec_aluctrl;
                  ImmOp   <= dec_use_imm ? imm_val : '0;
               end else begin
                  state <= IDLE;
               end
            end
            DECODE: begin
               if (legal) begin
                  state <= EXEC;
                  WE3   <= !is_bne && (ir[11:7] != 5'd0);
               end else begin
                  state   <= IDLE;
                  illegal <= 1'b1;
                  pc      <= pc + PC_STEP;
               end
            end
            EXEC: begin
               state  <= IDLE;
               retire <= 1'b1;
               pc     <= (is_bne && !EQ) ? pc + imm_val : pc + PC_STEP;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef INSTR_SEQ_RETIRE_CNT_EN
   // Count completed instructions; dropped illegal words are not counted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_cnt <= '0;
      end else if (retire) begin
         retire_cnt <= retire_cnt + DATA_WIDTH'(1);
      end else begin
         retire_cnt <= retire_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed, table-driven bench for instr_sequencer, plus hand-written sequences for
// back-to-back streaming and reset during EXEC.
module tb_instr_sequencer;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic        EQ;
   logic [4:0]  AD1;
   logic [4:0]  AD2;
   logic [4:0]  AD3;
   logic        WE3;
   logic        ALUsrc;
   logic        ALUctrl;
   logic [31:0] ImmOp;
   logic [31:0] pc;
   logic        retire;
   logic        illegal;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
   logic [31:0] retire_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   instr_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .EQ          (EQ),
      .AD1         (AD1),
      .AD2         (AD2),
      .AD3         (AD3),
      .WE3         (WE3),
      .ALUsrc      (ALUsrc),
      .ALUctrl     (ALUctrl),
      .ImmOp       (ImmOp),
      .pc          (pc),
      .retire      (retire),
      .illegal     (illegal)
`ifdef INSTR_SEQ_RETIRE_CNT_EN
      ,
      .retire_cnt  (retire_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] word;
      logic        eq;
      logic [4:0]  ad1;
      logic [4:0]  ad2;
      logic [4:0]  ad3;
      logic        alusrc;
      logic        aluctrl;
      logic [31:0] imm;
      logic        we;
      logic        ill;
      logic [31:0] pc_after;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int acc;
      int ret;
      int wes;

      // ADDI x1,x0,5 / ADD x3,x1,x2 / ADDI x0,x0,1 / illegal / BNE x1,x2,-8 (EQ=0, EQ=1)
      vecs[0] = '{32'h00500093, 1'b0, 5'd0,  5'd5,  5'd1,  1'b1, 1'b0, 32'd5, 1'b1, 1'b0, 32'h04};
      vecs[1] = '{32'h002081B3, 1'b0, 5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h08};
      vecs[2] = '{32'h00100013, 1'b0, 5'd0,  5'd1,  5'd0,  1'b1, 1'b0, 32'd1, 1'b0, 1'b0, 32'h0C};
      vecs[3] = '{32'hFFFFFFFF, 1'b0, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h10};
      vecs[4] = '{32'hFE209CE3, 1'b0, 5'd1,  5'd2,  5'd25, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 32'h08};
      vecs[5] = '{32'h00100013, 1'b0, 5'd0,  5'd1,  5'd0,  1'b1, 1'b0, 32'd1, 1'b0, 1'b0, 32'h0C};
      vecs[6] = '{32'h00100013, 1'b0, 5'd0,  5'd1,  5'd0,  1'b1, 1'b0, 32'd1, 1'b0, 1'b0, 32'h10};
      vecs[7] = '{32'hFE209CE3, 1'b1, 5'd1,  5'd2,  5'd25, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 32'h14};
      vecs[8] = '{32'h002081B3, 1'b0, 5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h18};

      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = 32'h0000_0000;
      EQ          = 1'b0;

      #12;
      chk("rst_ready",   {31'd0, instr_ready}, 32'd1);
      chk("rst_pc",      pc, 32'h0);
      chk("rst_we3",     {31'd0, WE3}, 32'd0);
      chk("rst_ad3",     {27'd0, AD3}, 32'd0);
      chk("rst_immop",   ImmOp, 32'd0);
      chk("rst_retire",  {31'd0, retire}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) begin
         instr       = vecs[i].word;
         instr_valid = 1'b1;
         EQ          = !vecs[i].eq;
         @(posedge clk);
         #1;
         instr_valid = 1'b0;
         instr       = 32'hFFFF_FFFF;
         chk($sformatf("v%0d_ready_dec", i), {31'd0, instr_ready}, 32'd0);
         chk($sformatf("v%0d_ad1", i),       {27'd0, AD1}, {27'd0, vecs[i].ad1});
         chk($sformatf("v%0d_ad2", i),       {27'd0, AD2}, {27'd0, vecs[i].ad2});
         chk($sformatf("v%0d_ad3", i),       {27'd0, AD3}, {27'd0, vecs[i].ad3});
         chk($sformatf("v%0d_alusrc", i),    {31'd0, ALUsrc}, {31'd0, vecs[i].alusrc});
         chk($sformatf("v%0d_aluctrl", i),   {31'd0, ALUctrl}, {31'd0, vecs[i].aluctrl});
         chk($sformatf("v%0d_immop", i),     ImmOp, vecs[i].imm);
         chk($sformatf("v%0d_we3_dec", i),   {31'd0, WE3}, 32'd0);
         chk($sformatf("v%0d_retire_dec", i), {31'd0, retire}, 32'd0);
         chk($sformatf("v%0d_illegal_dec", i), {31'd0, illegal}, 32'd0);
         if (vecs[i].ill) begin
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, 32'd1);
            chk($sformatf("v%0d_we3_ill", i), {31'd0, WE3}, 32'd0);
            chk($sformatf("v%0d_retire_ill", i), {31'd0, retire}, 32'd0);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].pc_after);
            chk($sformatf("v%0d_ready_end", i), {31'd0, instr_ready}, 32'd1);
         end else begin
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we3_exec", i), {31'd0, WE3}, {31'd0, vecs[i].we});
            chk($sformatf("v%0d_ready_exec", i), {31'd0, instr_ready}, 32'd0);
            chk($sformatf("v%0d_immop_hold", i), ImmOp, vecs[i].imm);
            EQ = vecs[i].eq;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_retire", i), {31'd0, retire}, 32'd1);
            chk($sformatf("v%0d_we3_end", i), {31'd0, WE3}, 32'd0);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].pc_after);
            chk($sformatf("v%0d_ready_end", i), {31'd0, instr_ready}, 32'd1);
         end
      end

      // Continuous valid with ADDI x0,x0,1: one accept every three cycles, no writes
      acc = 0;
      ret = 0;
      wes = 0;
      instr       = 32'h00100013;
      instr_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         acc += int'(instr_ready);
         @(posedge clk);
         #1;
         ret += int'(retire);
         wes += int'(WE3);
      end
      instr_valid = 1'b0;
      chk("stream_accepts", acc, 32'd4);
      chk("stream_retires", ret, 32'd4);
      chk("stream_we3",     wes, 32'd0);
      chk("stream_pc",      pc, 32'h28);
      chk("stream_ready",   {31'd0, instr_ready}, 32'd1);
`ifdef INSTR_SEQ_RETIRE_CNT_EN
      chk("retire_cnt", retire_cnt, 32'd12);
`endif

      // Reset asserted in the EXEC cycle of ADDI x1,x0,5
      instr       = 32'h00500093;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("rexec_we3_before", {31'd0, WE3}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rexec_we3",    {31'd0, WE3}, 32'd0);
      chk("rexec_pc",     pc, 32'h0);
      chk("rexec_ready",  {31'd0, instr_ready}, 32'd1);
      chk("rexec_ad3",    {27'd0, AD3}, 32'd0);
      chk("rexec_immop",  ImmOp, 32'd0);
      chk("rexec_alusrc", {31'd0, ALUsrc}, 32'd0);
`ifdef INSTR_SEQ_RETIRE_CNT_EN
      chk("rexec_retire_cnt", retire_cnt, 32'd0);
`endif
      @(posedge clk);
      #1;
      chk("rhold_we3",    {31'd0, WE3}, 32'd0);
      chk("rhold_retire", {31'd0, retire}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rrel_ready", {31'd0, instr_ready}, 32'd1);
      chk("rrel_pc",    pc, 32'h0);
      chk("rrel_we3",   {31'd0, WE3}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
